pe_operand_feeder: RTL and testbench
====================================

PE_OPERAND_FEEDER -- requirements
Module: pe_operand_feeder

Interface
REQ-001 Parameter N, default 4, meaning PE array rows = columns.
REQ-002 Parameter K, default 4, meaning inner dimension, i.e. operand waves per job.
REQ-003 Parameter TIMEOUT, default 15, meaning max cycles from pe_ready to pe_done before error.
REQ-004 clk  input  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 ld_valid  input  1  operand write strobe.
REQ-007 ld_sel  input  1  0 = matrix A (N x K), 1 = matrix B (K x N).
REQ-008 ld_addr  input  8  A: row*K+col; B: row*N+col.
REQ-009 ld_data  input  8  signed operand.
REQ-010 start  input  1  job request, sampled in IDLE only.
REQ-011 pe_done  input  1  done pulse from PE[0][0].
REQ-012 pe_clr  output  1  one-cycle clear, drives PE array rst.
REQ-013 pe_ready  output  1  one-cycle operand-valid strobe to all PEs.
REQ-014 a_bus  output  N*8  slice i = A[i][k], drives in_data1 of row i.
REQ-015 b_bus  output  N*8  slice j = B[k][j], drives in_data2 of column j.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 job_done  output  1  one-cycle pulse at job completion.
REQ-018 err  output  1  one-cycle pulse on illegal load or timeout.

Function
REQ-019 States IDLE, CLEAR, ISSUE, WAIT, GAP, FINISH; all outputs registered.
REQ-020 IDLE: ld_valid with in-range address writes the selected storage register at the clock edge.
REQ-021 Out-of-range address (A: >= N*K; B: >= K*N) SHALL not write and SHALL pulse err next cycle.
REQ-022 ld_valid while busy SHALL not write and SHALL pulse err.
REQ-023 IDLE + start -> CLEAR; k <= 0; simultaneous ld_valid and start: the write completes, then the job starts.
REQ-024 CLEAR: pe_clr=1 for exactly one cycle -> ISSUE.
REQ-025 ISSUE: pe_ready=1 for exactly one cycle; a_bus/b_bus carry wave k in the same cycle -> WAIT; timeout counter <= 0.
REQ-026 a_bus/b_bus SHALL hold wave k unchanged from ISSUE until the next ISSUE.
REQ-027 WAIT: pe_done=1 and k==K-1 -> FINISH; pe_done=1 and k<K-1 -> GAP, k <= k+1.
REQ-028 GAP lasts exactly one cycle -> ISSUE; the next pe_ready is 2 cycles after pe_done.
REQ-029 WAIT: the counter increments each cycle; when it reaches TIMEOUT without pe_done -> IDLE with err pulse and no job_done.
REQ-030 FINISH: job_done=1 for one cycle -> IDLE.
REQ-031 pe_done outside WAIT SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-032 Operand storage SHALL persist across jobs; a second start reuses the stored matrices.

Reset
REQ-033 rst SHALL force IDLE, k=0, counter=0, and outputs pe_clr, pe_ready, busy, job_done, err, a_bus, b_bus to 0.
REQ-034 rst SHALL clear operand storage to 0.
REQ-035 rst mid-job SHALL abort immediately with no job_done and no err.

Verification
REQ-036 Load A = I (4x4) and B[r][c] = r*4+c; start; PE model: done 11 cycles after ready -> pe_clr cycle, then 4 pe_ready pulses each 2 cycles after pe_done, waves b_bus = {3,2,1,0}, {7,6,5,4}, ...; job_done after the 4th done; PE results equal B.
REQ-037 Load all A = -128 and all B = -128 -> b_bus slices = 8'h80 and PE accumulators = 65536 each (K=4).
REQ-038 ld_addr = 16 with ld_sel = 0 -> err pulse; storage unchanged on readback via job.
REQ-039 Start, then withhold pe_done -> err pulse 15 cycles after pe_ready, busy falls, no job_done.
REQ-040 Assert rst during WAIT of wave 2 -> next cycle busy=0, buses=0; a new start runs a full 4-wave job correctly.
REQ-041 Assert start and ld_valid in the same IDLE cycle, then ld_valid during ISSUE -> first write lands, second write raises err, job proceeds unaffected.

Source files
------------

// File: rtl/pe_operand_feeder_if.sv
// Operand-load, job-control and PE-array handshake bundle for pe_operand_feeder.
// The slave modport is the feeder; the master modport is the loader/PE side.
interface pe_operand_feeder_if #(
    parameter int N = 4
);
    logic           ld_valid;
    logic           ld_sel;
    logic [7:0]     ld_addr;
    logic [7:0]     ld_data;
    logic           start;
    logic           pe_done;
    logic           pe_clr;
    logic           pe_ready;
    logic [N*8-1:0] a_bus;
    logic [N*8-1:0] b_bus;
    logic           busy;
    logic           job_done;
    logic           err;

    modport master (
        output ld_valid, ld_sel, ld_addr, ld_data, start, pe_done,
        input  pe_clr, pe_ready, a_bus, b_bus, busy, job_done, err
    );

    modport slave (
        input  ld_valid, ld_sel, ld_addr, ld_data, start, pe_done,
        output pe_clr, pe_ready, a_bus, b_bus, busy, job_done, err
    );
endinterface

// File: rtl/pe_operand_feeder.sv
// Stores A/B operand matrices and streams one column/row wave per PE handshake.
// All outputs registered (one cycle after the deciding edge); loads while busy are refused with err.
module pe_operand_feeder #(
    parameter int N       = 4,
    parameter int K       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    pe_operand_feeder_if.slave bus
);
    localparam int DEPTH = N * K;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int CW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, GAP, FINISH} state_t;

    state_t         state, state_n;
    logic [KW-1:0]  k, k_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           err_n;
    logic           wr_en;
    logic           addr_ok;
    logic [N*8-1:0] a_wave, b_wave;
    logic [7:0]     a_mem [DEPTH];
    logic [7:0]     b_mem [DEPTH];

    assign addr_ok = (int'(bus.ld_addr) < DEPTH);

    always_comb begin
        a_wave = '0;
        b_wave = '0;
        for (int i = 0; i < N; i++) begin
            a_wave[i*8 +: 8] = a_mem[AW'(i * K + int'(k))];
            b_wave[i*8 +: 8] = b_mem[AW'(int'(k) * N + i)];
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        cnt_n   = cnt;
        err_n   = 1'b0;
        wr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ld_valid) begin
                    if (addr_ok) wr_en = 1'b1;
                    else         err_n = 1'b1;
                end
                if (bus.start) begin
                    state_n = CLEAR;
                    k_n     = '0;
                end
            end
            CLEAR:  state_n = ISSUE;
            ISSUE: begin
                state_n = WAIT;
                cnt_n   = '0;
            end
            WAIT: begin
                if (bus.pe_done) begin
                    if (k == KW'(K - 1)) begin
                        state_n = FINISH;
                    end else begin
                        state_n = GAP;
                        k_n     = k + 1'b1;
                    end
                // cnt is 0 on the cycle after pe_ready, so the err cycle lands TIMEOUT cycles after it
                end else if (cnt == CW'(TIMEOUT - 2)) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP:    state_n = ISSUE;
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (bus.ld_valid && state != IDLE) err_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            k            <= '0;
            cnt          <= '0;
            bus.pe_clr   <= 1'b0;
            bus.pe_ready <= 1'b0;
            bus.busy     <= 1'b0;
            bus.job_done <= 1'b0;
            bus.err      <= 1'b0;
            bus.a_bus    <= '0;
            bus.b_bus    <= '0;
        end else begin
            state        <= state_n;
            k            <= k_n;
            cnt          <= cnt_n;
            bus.pe_clr   <= (state_n == CLEAR);
            bus.pe_ready <= (state_n == ISSUE);
            bus.busy     <= (state_n != IDLE);
            bus.job_done <= (state_n == FINISH);
            bus.err      <= err_n;
            // wave buses only change when a new wave is issued
            if (state_n == ISSUE) begin
                bus.a_bus <= a_wave;
                bus.b_bus <= b_wave;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                a_mem[d] <= '0;
                b_mem[d] <= '0;
            end
        end else if (wr_en) begin
            if (bus.ld_sel) b_mem[bus.ld_addr[AW-1:0]] <= bus.ld_data;
            else            a_mem[bus.ld_addr[AW-1:0]] <= bus.ld_data;
        end
    end
endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench: event-time plan per job plus a PE array model that accumulates A*B.
module tb_pe_operand_feeder;
    localparam int N  = 4;
    localparam int K  = 4;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_operand_feeder_if #(.N(N)) bus ();
    pe_operand_feeder #(.N(N), .K(K), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int cyc = 0;
    logic rst_s = 1'b0;
    int checks = 0;
    int failures = 0;

    int ma [N][K];
    int mb [K][N];
    int acc [N][N];

    int plan_clr = -1, plan_jd = -1, busy_lo = -1, busy_hi = -2;
    int ready_q [$];
    int err_q [$];
    logic [N*8-1:0] exp_a = '0, exp_b = '0;
    int pe_delay = -1, done_due = -1, job_s = 0, job_end = 0;
    logic stray_done = 1'b0;
    logic e_clr, e_rdy, e_jd, e_busy, e_err;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N*8-1:0] wave_a(input int w);
        logic [N*8-1:0] v;
        for (int i = 0; i < N; i++) v[i*8 +: 8] = ma[i][w][7:0];
        return v;
    endfunction

    function automatic logic [N*8-1:0] wave_b(input int w);
        logic [N*8-1:0] v;
        for (int j = 0; j < N; j++) v[j*8 +: 8] = mb[w][j][7:0];
        return v;
    endfunction

    // per-cycle comparison of every output against the planned event times
    initial forever begin
        @(negedge clk);
        if (cyc >= 1) begin
            if (rst_s) begin
                plan_clr = -1; plan_jd = -1; busy_lo = -1; busy_hi = -2;
                ready_q.delete();
                err_q.delete();
                exp_a = '0;
                exp_b = '0;
            end
            e_clr  = (cyc == plan_clr);
            e_jd   = (cyc == plan_jd);
            e_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            e_err  = 1'b0;
            foreach (err_q[x]) if (err_q[x] == cyc) e_err = 1'b1;
            e_rdy  = 1'b0;
            foreach (ready_q[x]) if (ready_q[x] == cyc) begin
                e_rdy = 1'b1;
                exp_a = wave_a(x);
                exp_b = wave_b(x);
            end
            check("pe_clr",   64'(bus.pe_clr),   64'(e_clr));
            check("pe_ready", 64'(bus.pe_ready), 64'(e_rdy));
            check("job_done", 64'(bus.job_done), 64'(e_jd));
            check("busy",     64'(bus.busy),     64'(e_busy));
            check("err",      64'(bus.err),      64'(e_err));
            check("a_bus",    64'(bus.a_bus),    64'(exp_a));
            check("b_bus",    64'(bus.b_bus),    64'(exp_b));
        end
    end

    // PE array: clear on pe_clr, multiply-accumulate on pe_ready
    initial forever begin
        @(negedge clk);
        if (bus.pe_clr === 1'b1)
            for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = 0;
        if (bus.pe_ready === 1'b1) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc[i][j] += int'($signed(bus.a_bus[i*8 +: 8])) * int'($signed(bus.b_bus[j*8 +: 8]));
            if (pe_delay >= 0) done_due = cyc + pe_delay;
        end
    end

    initial begin
        bus.pe_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) done_due = -1;
            bus.pe_done = stray_done || (cyc == done_due);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic note_load(input bit sel, input int addr, input int data, input int p);
        logic signed [7:0] t;
        t = 8'(data);
        if (addr < N * K) begin
            if (sel) mb[addr / N][addr % N] = int'(t);
            else     ma[addr / K][addr % K] = int'(t);
        end else begin
            err_q.push_back(p + 1);
        end
    endtask

    task automatic load(input bit sel, input int addr, input int data);
        bus.ld_valid = 1'b1;
        bus.ld_sel   = sel;
        bus.ld_addr  = 8'(addr);
        bus.ld_data  = 8'(data);
        note_load(sel, addr, data, cyc);
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic load_pattern(input int mode);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < K; c++)
                load(1'b0, r * K + c, (mode == 0) ? int'(r == c) : (mode == 1) ? -128 : r + c - 3);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < N; c++)
                load(1'b1, r * N + c, (mode == 0) ? r * N + c : (mode == 1) ? -128 : 2 * r - c);
    endtask

    // d < 0 means the PE never answers; with_ld loads in the same cycle as start
    task automatic start_job(input int d, input bit with_ld, input bit sel, input int addr, input int data);
        int last;
        job_s    = cyc;
        plan_clr = job_s + 1;
        busy_lo  = job_s + 1;
        ready_q.delete();
        if (d >= 0) begin
            for (int w = 0; w < K; w++) ready_q.push_back(job_s + 2 + w * (d + 2));
            last    = job_s + 2 + (K - 1) * (d + 2);
            plan_jd = last + d + 1;
            busy_hi = last + d + 1;
            job_end = last + d + 2;
        end else begin
            ready_q.push_back(job_s + 2);
            plan_jd = -1;
            busy_hi = job_s + 2 + TO - 1;
            err_q.push_back(job_s + 2 + TO);
            job_end = job_s + 2 + TO + 1;
        end
        pe_delay  = d;
        bus.start = 1'b1;
        if (with_ld) begin
            bus.ld_valid = 1'b1;
            bus.ld_sel   = sel;
            bus.ld_addr  = 8'(addr);
            bus.ld_data  = 8'(data);
            note_load(sel, addr, data, cyc);
        end
        tick();
        bus.start    = 1'b0;
        bus.ld_valid = 1'b0;
    endtask

    task automatic wait_to(input int c);
        int g = 0;
        while (cyc < c && g < 10000) begin
            tick();
            g++;
        end
        if (cyc < c) begin
            checks++;
            failures++;
            $display("FAIL wait_to got=%0d exp=%0d", cyc, c);
        end
    endtask

    task automatic check_acc();
        int e;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                e = 0;
                for (int w = 0; w < K; w++) e += ma[i][w] * mb[w][j];
                check("acc", 64'(acc[i][j]), 64'(e));
            end
    endtask

    initial begin
        rst = 1'b1;
        bus.ld_valid = 1'b0; bus.ld_sel = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) for (int j = 0; j < K; j++) begin ma[i][j] = 0; mb[j][i] = 0; end
        repeat (3) tick();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_b_bus", 64'(bus.b_bus), 64'd0);
        rst = 1'b0;
        tick();

        // identity A times counting B
        load_pattern(0);
        start_job(11, 1'b0, 1'b0, 0, 0);
        wait_to(job_s + 15);
        check("wave1_b", 64'(bus.b_bus), 64'h07060504);
        check("wave1_a", 64'(bus.a_bus), 64'h00000100);
        wait_to(job_end);
        check_acc();
        check("acc12", 64'(acc[1][2]), 64'd6);
        check("acc33", 64'(acc[3][3]), 64'd15);

        // most negative operands
        load_pattern(1);
        start_job(7, 1'b0, 1'b0, 0, 0);
        wait_to(job_end);
        check("neg_b_bus", 64'(bus.b_bus), 64'h80808080);
        check("neg_acc00", 64'(acc[0][0]), 64'd65536);
        check_acc();

        // out-of-range loads must not alias onto entry 0
        load(1'b0, 16, 8'h55);
        load(1'b1, 16, 8'h11);
        start_job(11, 1'b0, 1'b0, 0, 0);
        wait_to(job_end);
        check_acc();
        check("oor_acc21", 64'(acc[2][1]), 64'd65536);

        // PE never answers
        start_job(-1, 1'b0, 1'b0, 0, 0);
        wait_to(job_end);
        check("to_busy", 64'(bus.busy), 64'd0);

        // stray pe_done in IDLE, start+load together, then load/start/done during ISSUE
        load_pattern(2);
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        start_job(11, 1'b1, 1'b0, 0, 5);
        tick();
        bus.ld_valid = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = 8'd1; bus.ld_data = 8'd99;
        err_q.push_back(cyc + 1);
        bus.start  = 1'b1;
        stray_done = 1'b1;
        tick();
        bus.ld_valid = 1'b0;
        bus.start    = 1'b0;
        stray_done   = 1'b0;
        wait_to(job_end);
        check_acc();

        // reset in WAIT of wave 2 clears everything, then a fresh job
        load_pattern(0);
        start_job(11, 1'b0, 1'b0, 0, 0);
        wait_to(job_s + 30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_a_bus", 64'(bus.a_bus), 64'd0);
        check("abort_b_bus", 64'(bus.b_bus), 64'd0);
        for (int i = 0; i < N; i++) for (int j = 0; j < K; j++) begin ma[i][j] = 0; mb[j][i] = 0; end
        load_pattern(2);
        start_job(5, 1'b0, 1'b0, 0, 0);
        wait_to(job_end);
        check_acc();
        check("acc31", 64'(acc[3][1]), 64'd22);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
